window_stream_sequencer: RTL

Sequences one frame of pixels into five_by_five_window. Accepts a ready/valid upstream pixel stream and inserts per-line blanking cycles, which drives the window's din/validin/blanking_in. After the last pixel it flushes the window's fill latency with zero pixels. It also counts window outputs, flags early outputs and signals frame completion to the feature-detection control logic.

---
 rtl/window_stream_sequencer_pkg.sv | 23 ++
 rtl/line_slot_counter.sv | 45 ++++
 rtl/window_stream_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/window_stream_sequencer_pkg.sv
// Shared definitions for the window stream sequencer: state encoding, pixel
// width and the default frame geometry used by the window and the benches.
package window_stream_sequencer_pkg;

   localparam int PIX_W              = 8;
   localparam int DEF_LINE_LEN       = 400;
   localparam int DEF_BLANK_LEN      = 2;
   localparam int DEF_NUM_LINES      = 336;
   localparam int DEF_WINDOW_LATENCY = 1272;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } seq_state_t;

   // Bits needed to hold every value 0..max_count.
   function automatic int cnt_w(input int max_count);
      return (max_count < 1) ? 1 : $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/line_slot_counter.sv
// Slot position / line counter for one frame: advances on issued slots only,
// wraps the position at end of line and decodes the blanking tail of a line.
module line_slot_counter
   import window_stream_sequencer_pkg::*;
#(
   parameter int LINE_LEN  = DEF_LINE_LEN,
   parameter int BLANK_LEN = DEF_BLANK_LEN,
   parameter int NUM_LINES = DEF_NUM_LINES
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic advance,
   output logic blank,
   output logic last_slot
);

   localparam int POS_W  = cnt_w(LINE_LEN - 1);
   localparam int LINE_W = cnt_w(NUM_LINES);

   logic [POS_W-1:0]  pos;
   logic [LINE_W-1:0] line;
   logic              wrap;

   assign wrap      = (pos == POS_W'(LINE_LEN - 1));
   assign blank     = (pos >= POS_W'(LINE_LEN - BLANK_LEN));
   assign last_slot = wrap && (line == LINE_W'(NUM_LINES - 1));

   // The line count parks at NUM_LINES once the frame is in, so the flush
   // tail keeps the blanking pattern without the line counter wrapping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pos  <= '0;
         line <= '0;
      end else if (clear) begin
         pos  <= '0;
         line <= '0;
      end else if (advance) begin
         pos <= wrap ? '0 : pos + POS_W'(1);
         if (wrap && (line != LINE_W'(NUM_LINES)))
            line <= line + LINE_W'(1);
      end
   end

endmodule

// File: rtl/window_stream_sequencer.sv
// Feeds one frame of pixels into the 5x5 window with per-line blanking, flushes
// the window fill latency with zeros and collects/counts the window outputs.
module window_stream_sequencer
   import window_stream_sequencer_pkg::*;
#(
   parameter int LINE_LEN       = DEF_LINE_LEN,
   parameter int BLANK_LEN      = DEF_BLANK_LEN,
   parameter int NUM_LINES      = DEF_NUM_LINES,
   parameter int WINDOW_LATENCY = DEF_WINDOW_LATENCY
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic [PIX_W-1:0] win_din,
   output logic             win_validin,
   output logic             win_blanking,
   input  logic [PIX_W-1:0] win_dout,
   input  logic             win_validout,
   input  logic             win_blanking_out,
   output logic [PIX_W-1:0] res_data,
   output logic             res_valid,
   output logic             res_blanking,
   output logic             busy,
   output logic             frame_done,
   output logic             early_err
);

   localparam int TOTAL = NUM_LINES * LINE_LEN;
   localparam int LAT_W = cnt_w(WINDOW_LATENCY);
   localparam int OUT_W = cnt_w(TOTAL);

   seq_state_t       state, state_nx;
   logic             blank, last_slot;
   logic             issue, cap, done_now;
   logic [PIX_W-1:0] din_nx;
   logic [LAT_W-1:0] lat_cnt;
   logic [OUT_W-1:0] out_cnt;

   line_slot_counter #(
      .LINE_LEN  (LINE_LEN),
      .BLANK_LEN (BLANK_LEN),
      .NUM_LINES (NUM_LINES)
   ) u_slot (
      .clock     (clock),
      .reset     (reset),
      .clear     (state == IDLE),
      .advance   (issue),
      .blank     (blank),
      .last_slot (last_slot)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // A window beat counts only when it answers a slot presented this cycle.
   always_comb begin
      issue     = 1'b0;
      pix_ready = 1'b0;
      din_nx    = '0;
      cap       = 1'b0;
      state_nx  = state;
      if ((state == RUN || state == FLUSH) && !frame_done)
         cap = win_validin & win_validout;
      done_now = cap && (out_cnt == OUT_W'(TOTAL - 1));
      case (state)
         IDLE: begin
            if (start) state_nx = FILL;
         end
         FILL: begin
            pix_ready = ~blank;
            issue     = blank | pix_valid;
            din_nx    = (!blank && pix_valid) ? pix_data : '0;
            if (issue && last_slot)
               state_nx = FLUSH;
            else if (issue && (lat_cnt == LAT_W'(WINDOW_LATENCY - 1)))
               state_nx = RUN;
         end
         RUN: begin
            pix_ready = ~blank;
            issue     = blank | pix_valid;
            din_nx    = (!blank && pix_valid) ? pix_data : '0;
            if (frame_done)
               state_nx = IDLE;
            else if (issue && last_slot)
               state_nx = FLUSH;
         end
         FLUSH: begin
            // Stop feeding as soon as the final beat is in hand.
            issue = ~done_now & ~frame_done;
            if (frame_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         win_din      <= '0;
         win_validin  <= 1'b0;
         win_blanking <= 1'b0;
         res_data     <= '0;
         res_valid    <= 1'b0;
         res_blanking <= 1'b0;
         frame_done   <= 1'b0;
         early_err    <= 1'b0;
         lat_cnt      <= '0;
         out_cnt      <= '0;
      end else begin
         win_din      <= din_nx;
         win_validin  <= issue;
         win_blanking <= issue & blank;
         res_valid    <= cap;
         res_data     <= cap ? win_dout : '0;
         res_blanking <= cap & win_blanking_out;
         frame_done   <= done_now;
         early_err    <= early_err | ((state == FILL) & win_validout);
         if (state == IDLE)
            lat_cnt <= '0;
         else if (state == FILL && issue)
            lat_cnt <= lat_cnt + LAT_W'(1);
         if (state == IDLE)
            out_cnt <= '0;
         else if (cap)
            out_cnt <= out_cnt + OUT_W'(1);
      end
   end

endmodule
